mul_acc_pipe: RTL and testbench

//  Parametrised, fully pipelined HI/LO multiply / multiply-accumulate unit for the EX stage.

---
 rtl/mul_acc_pkg.sv | 37 +++
 rtl/mul_acc_pipe_core.sv | 75 +++++++
 rtl/mul_acc_pipe.sv | 165 ++++++++++++++++
 tb/tb_mul_acc_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_acc_pkg.sv
// Shared types and helpers for the pipelined HI/LO multiply / multiply-accumulate unit.
package mul_acc_pkg;

    localparam int unsigned MUL_ACC_TAG_MAX = 16;

    typedef enum logic [1:0] {
        MUL_MODE_MUL  = 2'b00,
        MUL_MODE_MADD = 2'b01,
        MUL_MODE_MSUB = 2'b10
    } mul_mode_e;

    // Sideband carried alongside each op; the tag field is sized for the widest supported tag
    typedef struct packed {
        logic                       valid;
        logic                       sign;
        mul_mode_e                  mode;
        logic                       chain;
        logic [MUL_ACC_TAG_MAX-1:0] tag;
    } mul_op_t;

    // Issue-to-result latency: MUL_STAGES multiplier stages plus the add/sub stage
    function automatic int unsigned mul_acc_lat(input int unsigned mul_stages);
        return mul_stages + 1;
    endfunction

    // Raw mode encoding 2'b11 behaves as a plain multiply
    function automatic mul_mode_e mul_acc_decode(input logic [1:0] raw);
        mul_mode_e m;
        case (raw)
            2'b01:   m = MUL_MODE_MADD;
            2'b10:   m = MUL_MODE_MSUB;
            default: m = MUL_MODE_MUL;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mul_acc_pipe_core.sv
// Operand capture, (WIDTH+1)-bit signed multiplier and MUL_STAGES-1 retiming registers,
// with a valid chain sharing one stall enable and a flush clear.
module mul_acc_pipe_core #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_sign,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    output logic [MUL_STAGES:0]   vld_o,
    output logic [2*WIDTH-1:0]    prod_o
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned FW = 2 * WIDTH + 2;

    logic [MUL_STAGES:0]   vld_q, vld_d;
    logic signed [WIDTH:0] a_q, a_d, b_q, b_d;
    logic signed [FW-1:0]  full;
    logic [PW-1:0]         pipe_q [MUL_STAGES];
    logic [PW-1:0]         pipe_d [MUL_STAGES];
    logic                  unused_ok;

    assign full      = FW'(a_q) * FW'(b_q);
    assign unused_ok = ^full[FW-1:PW];

    always_comb begin
        vld_d  = vld_q;
        a_d    = a_q;
        b_d    = b_q;
        pipe_d = pipe_q;
        if (flush) begin
            vld_d = '0;
        end else if (en) begin
            vld_d[0] = in_valid;
            for (int i = 1; i <= MUL_STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
            end
            pipe_d[0] = full[PW-1:0];
            for (int i = 1; i < MUL_STAGES; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
            // Extend by one bit so unsigned operands multiply correctly in a signed multiplier
            if (in_valid) begin
                a_d = {in_sign & in_a[WIDTH-1], in_a};
                b_d = {in_sign & in_b[WIDTH-1], in_b};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            a_q    <= a_d;
            b_q    <= b_d;
            pipe_q <= pipe_d;
        end
    end

    assign vld_o  = vld_q;
    assign prod_o = pipe_q[MUL_STAGES-1];

endmodule

// File: rtl/mul_acc_pipe.sv
// Pipelined HI/LO multiply / MADD / MSUB unit with valid/ready on both sides and flush.
// Optional result forwarding between back-to-back accumulate ops: define MUL_ACC_FWD_EN.
module mul_acc_pipe
    import mul_acc_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_STAGES = 3,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_srca,
    input  logic [WIDTH-1:0] in_srcb,
    input  logic [WIDTH-1:0] in_hi,
    input  logic [WIDTH-1:0] in_lo,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned DEPTH = mul_acc_lat(MUL_STAGES);
    localparam int unsigned LAST  = DEPTH - 1;

    logic             stall;
    logic             accept;
    logic             load;
    mul_mode_e        req_mode;
    logic [DEPTH-1:0] core_vld;
    logic [PW-1:0]    core_prod;
    mul_op_t          new_op;
    mul_op_t          last_op;
    mul_op_t          op_q  [DEPTH];
    mul_op_t          op_d  [DEPTH];
    logic [PW-1:0]    add_q [DEPTH];
    logic [PW-1:0]    add_d [DEPTH];
    logic [PW-1:0]    acc_val;
    logic [PW-1:0]    res;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_hi_q, out_hi_d;
    logic [WIDTH-1:0] out_lo_q, out_lo_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             unused_ok;

    assign stall    = out_valid_q && !out_ready;
    assign busy     = (|core_vld) || out_valid_q;
    assign req_mode = mul_acc_decode(in_mode);
`ifdef MUL_ACC_FWD_EN
    assign in_ready = !stall && !flush;
`else
    // Without forwarding an accumulate may only enter an empty pipe
    assign in_ready = !stall && !flush && !(in_valid && (req_mode != MUL_MODE_MUL) && busy);
`endif
    assign accept   = in_valid && in_ready;

    mul_acc_pipe_core #(
        .WIDTH      (WIDTH),
        .MUL_STAGES (MUL_STAGES)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (!stall),
        .flush    (flush),
        .in_valid (accept),
        .in_sign  (in_sign),
        .in_a     (in_srca),
        .in_b     (in_srcb),
        .vld_o    (core_vld),
        .prod_o   (core_prod)
    );

    // Op sideband and addend pipe, kept in lockstep with the core valid chain
    always_comb begin
        op_d         = op_q;
        add_d        = add_q;
        new_op       = '0;
        new_op.valid = 1'b1;
        new_op.sign  = in_sign;
        new_op.mode  = req_mode;
        new_op.chain = busy;
        new_op.tag   = MUL_ACC_TAG_MAX'(in_tag);
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_d[i].valid = 1'b0;
            end
        end else if (!stall) begin
            for (int i = 1; i < DEPTH; i++) begin
                op_d[i]  = op_q[i-1];
                add_d[i] = add_q[i-1];
            end
            op_d[0].valid = accept;
            if (accept) begin
                op_d[0]  = new_op;
                add_d[0] = {in_hi, in_lo};
            end
        end
    end

    // Add/sub stage and output register
    always_comb begin
        last_op = op_q[LAST];
`ifdef MUL_ACC_FWD_EN
        acc_val = last_op.chain ? {out_hi_q, out_lo_q} : add_q[LAST];
`else
        acc_val = add_q[LAST];
`endif
        case (last_op.mode)
            MUL_MODE_MADD: res = acc_val + core_prod;
            MUL_MODE_MSUB: res = acc_val - core_prod;
            default:       res = core_prod;
        endcase
        load        = !stall && !flush && core_vld[LAST] && last_op.valid;
        out_valid_d = out_valid_q;
        out_hi_d    = out_hi_q;
        out_lo_d    = out_lo_q;
        out_tag_d   = out_tag_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (!stall) begin
            out_valid_d = load;
        end
        if (load) begin
            out_hi_d  = res[PW-1:WIDTH];
            out_lo_d  = res[WIDTH-1:0];
            out_tag_d = TAG_W'(last_op.tag);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                add_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_hi_q    <= '0;
            out_lo_q    <= '0;
            out_tag_q   <= '0;
        end else begin
            op_q        <= op_d;
            add_q       <= add_d;
            out_valid_q <= out_valid_d;
            out_hi_q    <= out_hi_d;
            out_lo_q    <= out_lo_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign unused_ok = ^{last_op.sign, last_op.chain, last_op.tag};

    assign out_valid = out_valid_q;
    assign out_hi    = out_hi_q;
    assign out_lo    = out_lo_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_mul_acc_pipe.sv
// Directed bench for mul_acc_pipe at WIDTH=32, MUL_STAGES=3 (latency 4).
module tb_mul_acc_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [1:0]  in_mode;
    logic [31:0] in_srca;
    logic [31:0] in_srcb;
    logic [31:0] in_hi;
    logic [31:0] in_lo;
    logic [3:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic [3:0]  out_tag;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        sign;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  tag;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [10];

    mul_acc_pipe #(
        .WIDTH      (32),
        .MUL_STAGES (3),
        .TAG_W      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_mode   (in_mode),
        .in_srca   (in_srca),
        .in_srcb   (in_srcb),
        .in_hi     (in_hi),
        .in_lo     (in_lo),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hi    (out_hi),
        .out_lo    (out_lo),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sign   = v.sign;
        in_mode   = v.mode;
        in_srca   = v.a;
        in_srcb   = v.b;
        in_hi     = v.hi;
        in_lo     = v.lo;
        in_tag    = v.tag;
        out_ready = 1'b1;
        #1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_srca  = 32'hDEAD_BEEF;
        in_hi    = 32'h5555_AAAA;
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(4));
        chk($sformatf("v%0d_hi", idx), 64'(out_hi), 64'(v.exp_hi));
        chk($sformatf("v%0d_lo", idx), 64'(out_lo), 64'(v.exp_lo));
        chk($sformatf("v%0d_tag", idx), 64'(out_tag), 64'(v.tag));
        @(negedge clk);
        chk($sformatf("v%0d_valid_drop", idx), 64'(out_valid), 64'(0));
        chk($sformatf("v%0d_hi_kept", idx), 64'(out_hi), 64'(v.exp_hi));
        chk($sformatf("v%0d_idle", idx), 64'(busy), 64'(0));
    endtask

    task automatic seq_stall();
        int issued = 0;
        int got    = 0;
        int stalls = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready = !(c >= 6 && c <= 8);
            if (issued < 4) begin
                in_valid = 1'b1;
                in_sign  = 1'b0;
                in_mode  = 2'b00;
                in_srca  = 32'(issued + 1);
                in_srcb  = 32'd10;
                in_tag   = 4'(issued + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                chk("stall_in_ready", 64'(in_ready), 64'(0));
            end
            if (out_valid && out_ready) begin
                chk("stall_hi", 64'(out_hi), 64'(0));
                chk("stall_lo", 64'(out_lo), 64'((got + 1) * 10));
                chk("stall_tag", 64'(out_tag), 64'(got + 1));
                got++;
            end
            if (in_valid && in_ready) issued++;
        end
        chk("stall_cycles", 64'(stalls), 64'(3));
        chk("stall_count", 64'(got), 64'(4));
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic seq_flush();
        int seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sign  = 1'b0;
            in_mode  = 2'b00;
            in_srca  = 32'(c + 1);
            in_srcb  = 32'd7;
            in_tag   = 4'(c + 8);
            #1;
            chk("flush_issue_ready", 64'(in_ready), 64'(1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        chk("flush_busy_before", 64'(busy), 64'(1));
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_busy_after", 64'(busy), 64'(0));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_output", 64'(seen), 64'(0));
    endtask

    task automatic seq_chain();
        bit madd_done = 1'b0;
        int acc_c     = -1;
        int got       = 0;
        logic [31:0] exp_madd;
        int exp_c;
`ifdef MUL_ACC_FWD_EN
        exp_madd = 32'd26;
        exp_c    = 1;
`else
        exp_madd = 32'd20;
        exp_c    = 6;
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 0) begin
                in_valid = 1'b1;
                in_sign  = 1'b0;
                in_mode  = 2'b00;
                in_srca  = 32'd2;
                in_srcb  = 32'd3;
                in_hi    = 32'd0;
                in_lo    = 32'd0;
                in_tag   = 4'd5;
            end else if (!madd_done) begin
                in_valid = 1'b1;
                in_mode  = 2'b01;
                in_srca  = 32'd4;
                in_srcb  = 32'd5;
                in_tag   = 4'd6;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                chk("chain_hi", 64'(out_hi), 64'(0));
                chk("chain_lo", 64'(out_lo), (got == 0) ? 64'(6) : 64'(exp_madd));
                chk("chain_tag", 64'(out_tag), (got == 0) ? 64'(5) : 64'(6));
                got++;
            end
            if (c > 0 && !madd_done && in_valid && in_ready) begin
                madd_done = 1'b1;
                acc_c     = c;
            end
        end
        chk("chain_issue_cycle", 64'(acc_c), 64'(exp_c));
        chk("chain_count", 64'(got), 64'(2));
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'b00, 32'hFFFF_FFFD, 32'd7,         32'd0,         32'd0,         4'h1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd0,         4'h2, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd0,         4'h3, 32'h0000_0000, 32'h0000_0001};
        vecs[3] = '{1'b0, 2'b01, 32'd2,         32'd3,         32'd0,         32'hFFFF_FFFF, 4'h4, 32'h0000_0001, 32'h0000_0005};
        vecs[4] = '{1'b0, 2'b10, 32'd2,         32'd3,         32'd0,         32'd0,         4'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[5] = '{1'b0, 2'b11, 32'd5,         32'd6,         32'h1234_5678, 32'd9,         4'h6, 32'h0000_0000, 32'h0000_001E};
        vecs[6] = '{1'b1, 2'b10, 32'hFFFF_FFFE, 32'd3,         32'd0,         32'd16,        4'h7, 32'h0000_0000, 32'h0000_0016};
        vecs[7] = '{1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'd0,         32'd0,         4'h8, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{1'b0, 2'b00, 32'h8000_0000, 32'd2,         32'd0,         32'd0,         4'h9, 32'h0000_0001, 32'h0000_0000};
        vecs[9] = '{1'b0, 2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd1,         4'hA, 32'h0000_0000, 32'h0000_0000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_mode   = 2'b00;
        in_srca   = '0;
        in_srcb   = '0;
        in_hi     = '0;
        in_lo     = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_hi", 64'(out_hi), 64'(0));
        chk("rst_out_lo", 64'(out_lo), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        seq_stall();
        seq_flush();
        run_vec(vecs[0], 10);
        seq_chain();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
